// File: rtl/mcpu_pkg.sv
// ============================================================================
// Module : mcpu_pkg
// Brief  : Shared fetch-FSM state encoding and FIFO entry sizing for mcpu_ifetch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mcpu_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_t;

  localparam int c_IROM_ADDR_BITS_DEF = 14;
  localparam int c_ENTRY_W_DEF        = c_IROM_ADDR_BITS_DEF + 8;

  // Each prefetch entry carries {rom address, byte}.
  function automatic int entry_width(input int addr_bits);
    return addr_bits + 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mcpu_ifetch_fifo.sv
// ============================================================================
// Module : mcpu_ifetch_fifo
// Brief  : Prefetch FIFO with dual push, single pop and synchronous flush.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mcpu_ifetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 22
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push0,
  input  logic                     i_push1,
  input  logic [WIDTH-1:0]         i_din0,
  input  logic [WIDTH-1:0]         i_din1,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = c_PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_PW-1:0]  r_rd_ptr;
  logic [c_PW-1:0]  r_wr_ptr;
  logic [c_CW-1:0]  r_count;
  logic [c_PW-1:0]  w_wr_ptr1;
  logic [c_CW-1:0]  w_npush;
  logic [c_CW-1:0]  w_npop;

  assign w_wr_ptr1 = r_wr_ptr + c_PW'(1);
  assign w_npush   = {{(c_CW-1){1'b0}}, i_push0} + {{(c_CW-1){1'b0}}, i_push1};
  assign w_npop    = {{(c_CW-1){1'b0}}, i_pop};

  // push1 is only ever asserted together with push0, so it lands one slot later.
  always_ff @(posedge clk) begin
    if (i_push0 && !i_flush) r_mem[r_wr_ptr]  <= i_din0;
    if (i_push1 && !i_flush) r_mem[w_wr_ptr1] <= i_din1;
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + w_npush[c_PW-1:0];
      r_rd_ptr <= r_rd_ptr + w_npop[c_PW-1:0];
      r_count  <= r_count + w_npush - w_npop;
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/mcpu_ifetch.sv
// ============================================================================
// Module : mcpu_ifetch
// Brief  : Dual-port instruction fetch sequencer feeding a byte-wide decoder.
//          Optional MCPU_IFETCH_STATS_EN adds saturating fetch/flush counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mcpu_ifetch
  import mcpu_pkg::*;
#(
  parameter int          IROM_ADDR_BITS = 14,
  parameter int          FIFO_DEPTH     = 4,
  parameter int unsigned RESET_ADDR     = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [IROM_ADDR_BITS-1:0] irom_addr0,
  input  logic [7:0]                irom_out0,
  output logic [IROM_ADDR_BITS-1:0] irom_addr1,
  input  logic [7:0]                irom_out1,
  input  logic                      redirect_valid,
  input  logic [IROM_ADDR_BITS-1:0] redirect_addr,
  input  logic                      halt_req,
  output logic                      instr_valid,
  output logic [7:0]                instr_data,
  output logic [IROM_ADDR_BITS-1:0] instr_addr,
  input  logic                      instr_ready,
  output logic                      halted
`ifdef MCPU_IFETCH_STATS_EN
  ,
  output logic [15:0]               fetch_count,
  output logic [15:0]               flush_count
`endif
);

  localparam int                 c_AW         = IROM_ADDR_BITS;
  localparam int                 c_ENTRY_W    = entry_width(IROM_ADDR_BITS);
  localparam int                 c_CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [c_AW-1:0]    c_RESET_ADDR = c_AW'(RESET_ADDR);
  localparam logic [c_CW-1:0]    c_DEPTH      = c_CW'(FIFO_DEPTH);
  localparam logic [c_CW-1:0]    c_TWO        = c_CW'(2);

  fetch_state_t          r_state;
  fetch_state_t          w_state_n;
  logic [c_AW-1:0]       r_fpc;
  logic [c_AW-1:0]       w_fpc_n;
  logic [c_AW-1:0]       w_fpc_p1;
  logic [c_AW-1:0]       w_fpc_p2;
  logic                  w_push0;
  logic                  w_push1;
  logic                  w_pop;
  logic                  w_empty;
  logic [c_CW-1:0]       w_count;
  logic [c_CW-1:0]       w_free;
  logic [c_ENTRY_W-1:0]  w_head;
  logic [c_ENTRY_W-1:0]  w_din0;
  logic [c_ENTRY_W-1:0]  w_din1;

  assign w_fpc_p1   = r_fpc + c_AW'(1);
  assign w_fpc_p2   = r_fpc + c_AW'(2);
  assign irom_addr0 = r_fpc;
  assign irom_addr1 = w_fpc_p1;
  assign w_din0     = {r_fpc, irom_out0};
  assign w_din1     = {w_fpc_p1, irom_out1};

  // A redirect discards the head, so it must not count as a consumed pop.
  assign w_pop  = instr_valid && instr_ready && !redirect_valid;
  assign w_free = c_DEPTH - w_count + {{(c_CW-1){1'b0}}, w_pop};

  assign instr_valid = !w_empty;
  assign instr_data  = w_empty ? 8'd0 : w_head[7:0];
  assign instr_addr  = w_empty ? '0   : w_head[c_ENTRY_W-1:8];
  assign halted      = (r_state == S_HALT) && w_empty;

  mcpu_ifetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (c_ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push0 (w_push0),
    .i_push1 (w_push1),
    .i_din0  (w_din0),
    .i_din1  (w_din1),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_dout  (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_state_n = r_state;
    w_fpc_n   = r_fpc;
    w_push0   = 1'b0;
    w_push1   = 1'b0;
    if (redirect_valid) begin
      w_fpc_n   = redirect_addr;
      w_state_n = halt_req ? S_HALT : S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (halt_req) begin
            w_state_n = S_HALT;
          end else if (w_free >= c_TWO) begin
            w_push0 = 1'b1;
            w_push1 = 1'b1;
            w_fpc_n = w_fpc_p2;
          end else if (w_free != '0) begin
            w_push0 = 1'b1;
            w_fpc_n = w_fpc_p1;
          end else begin
            w_state_n = S_HOLD;
          end
        end
        S_HOLD: begin
          if (halt_req)            w_state_n = S_HALT;
          else if (w_free != '0)   w_state_n = S_FETCH;
        end
        S_HALT:  w_state_n = S_HALT;
        default: w_state_n = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_fpc   <= c_RESET_ADDR;
    end else begin
      r_state <= w_state_n;
      r_fpc   <= w_fpc_n;
    end
  end

`ifdef MCPU_IFETCH_STATS_EN
  logic [15:0] r_fetch_count;
  logic [15:0] r_flush_count;
  logic [1:0]  w_npush;
  logic [16:0] w_fetch_sum;

  assign w_npush     = {1'b0, w_push0} + {1'b0, w_push1};
  assign w_fetch_sum = {1'b0, r_fetch_count} + {15'd0, w_npush};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_count <= 16'd0;
      r_flush_count <= 16'd0;
    end else begin
      r_fetch_count <= w_fetch_sum[16] ? 16'hFFFF : w_fetch_sum[15:0];
      if (redirect_valid && (r_flush_count != 16'hFFFF))
        r_flush_count <= r_flush_count + 16'd1;
    end
  end

  assign fetch_count = r_fetch_count;
  assign flush_count = r_flush_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mcpu_ifetch.sv
// ============================================================================
// Module : tb_mcpu_ifetch
// Brief  : Scenario tasks plus a randomized run against an in-order byte-stream
//          model of the fetch unit. Honors MCPU_IFETCH_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mcpu_ifetch;

  localparam int AW = 14;

  logic          clk;
  logic          reset;
  logic [AW-1:0] irom_addr0;
  logic [7:0]    irom_out0;
  logic [AW-1:0] irom_addr1;
  logic [7:0]    irom_out1;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic          halt_req;
  logic          instr_valid;
  logic [7:0]    instr_data;
  logic [AW-1:0] instr_addr;
  logic          instr_ready;
  logic          halted;
`ifdef MCPU_IFETCH_STATS_EN
  logic [15:0]   fetch_count;
  logic [15:0]   flush_count;
`endif

  logic [7:0] rom [0:(1<<AW)-1];
  int checks;
  int failures;

  assign irom_out0 = rom[irom_addr0];
  assign irom_out1 = rom[irom_addr1];

  mcpu_ifetch #(
    .IROM_ADDR_BITS (AW),
    .FIFO_DEPTH     (4),
    .RESET_ADDR     (0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .irom_addr0     (irom_addr0),
    .irom_out0      (irom_out0),
    .irom_addr1     (irom_addr1),
    .irom_out1      (irom_out1),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .halt_req       (halt_req),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_addr     (instr_addr),
    .instr_ready    (instr_ready),
    .halted         (halted)
`ifdef MCPU_IFETCH_STATS_EN
    ,
    .fetch_count    (fetch_count),
    .flush_count    (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect_valid = 1'b0; halt_req = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    instr_ready = 1'b1; redirect_addr = '0;
    reset = 1'b1; redirect_valid = 1'b0; halt_req = 1'b0;
    tick(); tick();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", instr_valid); end
    checks++; if (instr_data !== 8'd0) begin failures++; $display("FAIL rst_data got=%0h exp=0", instr_data); end
    checks++; if (instr_addr !== '0) begin failures++; $display("FAIL rst_addr got=%0h exp=0", instr_addr); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted got=%0h exp=0", halted); end
    checks++; if (irom_addr0 !== 14'h0 || irom_addr1 !== 14'h1) begin failures++; $display("FAIL rst_irom got=%0h/%0h exp=0/1", irom_addr0, irom_addr1); end
`ifdef MCPU_IFETCH_STATS_EN
    checks++; if (fetch_count !== 16'd0 || flush_count !== 16'd0) begin failures++; $display("FAIL rst_stats got=%0h/%0h exp=0/0", fetch_count, flush_count); end
`endif
    reset = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_release_valid got=%0h exp=0", instr_valid); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_addr !== 14'h0 || instr_data !== 8'h10) begin
      failures++; $display("FAIL first_valid got=%0h/%0h/%0h exp=1/0/10", instr_valid, instr_addr, instr_data); end
  endtask

  task automatic test_stream();
    logic [AW-1:0] exp;
    exp = '0;
    for (int i = 0; i < 12; i++) begin
      checks++; if (instr_valid !== 1'b1 || instr_addr !== exp || instr_data !== rom[exp]) begin
        failures++; $display("FAIL stream[%0d] got=%0h/%0h/%0h exp=1/%0h/%0h", i, instr_valid, instr_addr, instr_data, exp, rom[exp]); end
      exp = exp + 1'b1;
      tick();
    end
  endtask

  task automatic test_fill_hold();
    instr_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    checks++; if (instr_valid !== 1'b1 || instr_addr !== 14'h0 || instr_data !== 8'h10) begin
      failures++; $display("FAIL hold_head got=%0h/%0h/%0h exp=1/0/10", instr_valid, instr_addr, instr_data); end
    checks++; if (irom_addr0 !== 14'h4 || irom_addr1 !== 14'h5) begin
      failures++; $display("FAIL hold_fpc got=%0h/%0h exp=4/5", irom_addr0, irom_addr1); end
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (instr_valid !== 1'b1 || instr_addr !== AW'(i) || instr_data !== 8'(8'h10 + i)) begin
        failures++; $display("FAIL hold_resume[%0d] got=%0h/%0h/%0h exp=1/%0h/%0h", i, instr_valid, instr_addr, instr_data, i, 8'h10 + i); end
      tick();
    end
  endtask

  task automatic test_redirect_wrap();
    logic [AW-1:0] exp;
    instr_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    redirect_valid = 1'b1; redirect_addr = 14'h3FFE;
    tick();
    redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL redir_bubble got=%0h exp=0", instr_valid); end
    checks++; if (irom_addr0 !== 14'h3FFE || irom_addr1 !== 14'h3FFF) begin
      failures++; $display("FAIL redir_fpc got=%0h/%0h exp=3ffe/3fff", irom_addr0, irom_addr1); end
    instr_ready = 1'b1;
    tick();
    exp = 14'h3FFE;
    for (int i = 0; i < 4; i++) begin
      checks++; if (instr_valid !== 1'b1 || instr_addr !== exp || instr_data !== rom[exp]) begin
        failures++; $display("FAIL wrap_stream[%0d] got=%0h/%0h/%0h exp=1/%0h/%0h", i, instr_valid, instr_addr, instr_data, exp, rom[exp]); end
      exp = exp + 1'b1;
      tick();
    end
    redirect_valid = 1'b1; redirect_addr = 14'h3FFF;
    tick();
    redirect_valid = 1'b0;
    checks++; if (irom_addr0 !== 14'h3FFF || irom_addr1 !== 14'h0000) begin
      failures++; $display("FAIL irom_wrap got=%0h/%0h exp=3fff/0", irom_addr0, irom_addr1); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_addr !== 14'h3FFF) begin
      failures++; $display("FAIL wrap_head got=%0h/%0h exp=1/3fff", instr_valid, instr_addr); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_addr !== 14'h0000 || instr_data !== rom[0]) begin
      failures++; $display("FAIL wrap_next got=%0h/%0h/%0h exp=1/0/%0h", instr_valid, instr_addr, instr_data, rom[0]); end
  endtask

  task automatic test_redirect_pop();
    instr_ready = 1'b1;
    do_reset();
    tick(); tick(); tick();
    checks++; if (instr_valid !== 1'b1 || instr_addr !== 14'h2 || instr_data !== 8'h12) begin
      failures++; $display("FAIL rp_head got=%0h/%0h/%0h exp=1/2/12", instr_valid, instr_addr, instr_data); end
    redirect_valid = 1'b1; redirect_addr = 14'h0200;
    tick();
    redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rp_bubble got=%0h exp=0", instr_valid); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_addr !== 14'h0200 || instr_data !== rom[14'h0200]) begin
      failures++; $display("FAIL rp_first got=%0h/%0h/%0h exp=1/200/%0h", instr_valid, instr_addr, instr_data, rom[14'h0200]); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_addr !== 14'h0201) begin
      failures++; $display("FAIL rp_second got=%0h/%0h exp=1/201", instr_valid, instr_addr); end
  endtask

  task automatic test_halt();
    instr_ready = 1'b1;
    do_reset();
    tick(); tick();
    halt_req = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      checks++; if (instr_valid !== 1'b1 || instr_addr !== AW'(i) || instr_data !== rom[i]) begin
        failures++; $display("FAIL halt_drain[%0d] got=%0h/%0h/%0h exp=1/%0h/%0h", i, instr_valid, instr_addr, instr_data, i, rom[i]); end
      tick();
    end
    checks++; if (instr_valid !== 1'b0 || halted !== 1'b1) begin
      failures++; $display("FAIL halt_done got=%0h/%0h exp=0/1", instr_valid, halted); end
    checks++; if (irom_addr0 !== 14'h4) begin failures++; $display("FAIL halt_frozen got=%0h exp=4", irom_addr0); end
    halt_req = 1'b0;
    tick(); tick(); tick();
    checks++; if (halted !== 1'b1 || instr_valid !== 1'b0 || irom_addr0 !== 14'h4) begin
      failures++; $display("FAIL halt_sticky got=%0h/%0h/%0h exp=1/0/4", halted, instr_valid, irom_addr0); end
    redirect_valid = 1'b1; redirect_addr = 14'h0100;
    tick();
    redirect_valid = 1'b0;
    checks++; if (halted !== 1'b0 || instr_valid !== 1'b0) begin
      failures++; $display("FAIL halt_exit got=%0h/%0h exp=0/0", halted, instr_valid); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_addr !== 14'h0100) begin
      failures++; $display("FAIL halt_resume got=%0h/%0h exp=1/100", instr_valid, instr_addr); end
  endtask

  task automatic test_reset_mid();
    instr_ready = 1'b1;
    do_reset();
    redirect_valid = 1'b1; redirect_addr = 14'h0040;
    tick();
    redirect_valid = 1'b0; instr_ready = 1'b0;
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_addr !== 14'h0040) begin
      failures++; $display("FAIL mid_pre got=%0h/%0h exp=1/40", instr_valid, instr_addr); end
`ifdef MCPU_IFETCH_STATS_EN
    checks++; if (fetch_count !== 16'd2 || flush_count !== 16'd1) begin
      failures++; $display("FAIL mid_stats_pre got=%0h/%0h exp=2/1", fetch_count, flush_count); end
`endif
    reset = 1'b1; redirect_valid = 1'b1; redirect_addr = 14'h0055; instr_ready = 1'b1;
    tick();
    checks++; if (instr_valid !== 1'b0 || irom_addr0 !== 14'h0) begin
      failures++; $display("FAIL mid_reset got=%0h/%0h exp=0/0", instr_valid, irom_addr0); end
`ifdef MCPU_IFETCH_STATS_EN
    checks++; if (fetch_count !== 16'd0 || flush_count !== 16'd0) begin
      failures++; $display("FAIL mid_stats got=%0h/%0h exp=0/0", fetch_count, flush_count); end
`endif
    reset = 1'b0; redirect_valid = 1'b0;
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_addr !== 14'h0) begin
      failures++; $display("FAIL mid_restart got=%0h/%0h exp=1/0", instr_valid, instr_addr); end
  endtask

  // Model: consumed bytes form the ROM sequence from the last fetch origin;
  // a halted, un-redirected fetch unit is idle and frozen.
  task automatic test_random();
    logic [AW-1:0] exp;
    logic [AW-1:0] frozen;
    logic          freeze_active;
    logic          prev_redirect;
    int            nredir;
    for (int a = 0; a < (1 << AW); a++) rom[a] = 8'($urandom);
    instr_ready = 1'b0;
    do_reset();
    exp = '0; freeze_active = 1'b0; prev_redirect = 1'b0; nredir = 0; frozen = '0;
    for (int c = 0; c < 3000; c++) begin
      instr_ready    = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 99) < 4);
      redirect_addr  = AW'($urandom);
      halt_req       = ($urandom_range(0, 99) < 3);
      #1;
      checks++; if (irom_addr1 !== AW'(irom_addr0 + 1'b1)) begin
        failures++; $display("FAIL rnd_addr1[%0d] got=%0h exp=%0h", c, irom_addr1, AW'(irom_addr0 + 1'b1)); end
      if (halted) begin
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rnd_halt_valid[%0d] got=1 exp=0", c); end
      end
      if (prev_redirect) begin
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rnd_bubble[%0d] got=1 exp=0", c); end
      end
      if (freeze_active) begin
        checks++; if (halted !== 1'b1 || irom_addr0 !== frozen) begin
          failures++; $display("FAIL rnd_frozen[%0d] got=%0h/%0h exp=1/%0h", c, halted, irom_addr0, frozen); end
      end
      if (instr_valid && instr_ready && !redirect_valid) begin
        checks++; if (instr_addr !== exp || instr_data !== rom[exp]) begin
          failures++; $display("FAIL rnd_pop[%0d] got=%0h/%0h exp=%0h/%0h", c, instr_addr, instr_data, exp, rom[exp]); end
        exp = exp + 1'b1;
      end
      if (redirect_valid) begin
        exp = redirect_addr; freeze_active = 1'b0; nredir++;
      end else if (halted && !freeze_active) begin
        freeze_active = 1'b1; frozen = irom_addr0;
      end
      prev_redirect = redirect_valid;
      tick();
    end
    redirect_valid = 1'b0; halt_req = 1'b0;
`ifdef MCPU_IFETCH_STATS_EN
    checks++; if (flush_count !== 16'(nredir)) begin
      failures++; $display("FAIL rnd_flush_count got=%0d exp=%0d", flush_count, nredir); end
`else
    checks++; if (nredir == 0) begin failures++; $display("FAIL rnd_no_redirects got=0 exp>0"); end
`endif
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; redirect_valid = 1'b0; redirect_addr = '0; halt_req = 1'b0; instr_ready = 1'b0;
    for (int a = 0; a < (1 << AW); a++) rom[a] = 8'(a + 16);
    test_reset();
    test_stream();
    test_fill_hold();
    test_redirect_wrap();
    test_redirect_pop();
    test_halt();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mcpu_ifetch.md
Name: mcpu_ifetch

Overview:
Instruction-fetch sequencer for the dual-read-port instruction ROM (mcpu_irom).
- Drives both ROM address ports every cycle, fetching up to two consecutive bytes per clock into a small prefetch FIFO.
- Presents one byte per cycle to the decoder over a valid/ready handshake.
- Handles PC redirects (jumps/branches) by flushing, and a halt request by freezing fetch.

Parameters:
IROM_ADDR_BITS, 14, ROM address width; all fetch addresses wrap modulo 2**IROM_ADDR_BITS.
FIFO_DEPTH, 4, prefetch entries; power of two, >= 2.
RESET_ADDR, 0, fetch address loaded on reset.

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
irom_addr0  out  IROM_ADDR_BITS  ROM port 0 address (= fpc).
irom_out0  in  8  ROM port 0 data, combinational from irom_addr0.
irom_addr1  out  IROM_ADDR_BITS  ROM port 1 address (= fpc+1, wrapped).
irom_out1  in  8  ROM port 1 data.
redirect_valid  in  1  load new fetch address this cycle.
redirect_addr  in  IROM_ADDR_BITS  new fetch address.
halt_req  in  1  stop fetching (level).
instr_valid  out  1  head entry valid.
instr_data  out  8  head byte.
instr_addr  out  IROM_ADDR_BITS  ROM address of head byte.
instr_ready  in  1  consumer accepts head this cycle.
halted  out  1  FSM in S_HALT and FIFO empty.

Behaviour:
- Reset values: fpc=RESET_ADDR, FIFO empty, state=S_FETCH, instr_valid=0, instr_data=0, instr_addr=0, halted=0.
- Only one clock domain and one reset; reset wins over every other input, including mid-redirect.
- ROM is combinational; bytes are captured into the FIFO at the clock edge. First instr_valid=1 appears one cycle after reset deasserts.
- Pop: when instr_valid && instr_ready, the head is removed at the edge.
- Push count per cycle in S_FETCH:
  - free = FIFO_DEPTH - count + (pop ? 1 : 0).
  - free >= 2: push irom_out0 and irom_out1; fpc += 2.
  - free == 1: push irom_out0 only; fpc += 1.
  - free == 0: no push.
  - Each pushed entry stores {addr, byte}.
- Wrap: fpc and fpc+1 are computed modulo 2**IROM_ADDR_BITS. At fpc = 0x3FFF (default width), irom_addr1 = 0x0000.
- FSM:
  - S_FETCH: normal operation. Goes to S_HOLD when free == 0. Goes to S_HALT when halt_req = 1.
  - S_HOLD: no push. Returns to S_FETCH when free > 0. Goes to S_HALT when halt_req = 1.
  - S_HALT: no push; pops continue so the FIFO drains. Leaves to S_FETCH only on redirect_valid or reset; deasserting halt_req alone does not resume.
- Redirect priority: redirect_valid > halt_req > pop/push.
  - On redirect_valid, at the edge: the FIFO is flushed (a pop in the same cycle is discarded), fpc <= redirect_addr, and no push occurs that cycle.
  - Next cycle instr_valid = 0; the first redirected byte is valid the cycle after that.
- Simultaneous redirect_valid and halt_req: the redirect is applied (flush + fpc load) and the state becomes S_HALT.
- halted = (state == S_HALT) && FIFO empty.

Optional Feature:
MCPU_IFETCH_STATS_EN
- Defined: adds outputs fetch_count[15:0] and flush_count[15:0], both reset to 0 and saturating at 0xFFFF.
  - fetch_count increments by the number of bytes pushed each cycle (0, 1 or 2).
  - flush_count increments by 1 per redirect.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package/header mcpu_pkg: FSM state encoding (S_FETCH=0, S_HOLD=1, S_HALT=2, 2 bits) and the FIFO entry width constant (IROM_ADDR_BITS+8).
- Sub-module mcpu_ifetch_fifo: synchronous FIFO, dual push (push0/push1), single pop, flush, count output; parameterised by depth and entry width.
- Top level holds the FSM, fpc and the redirect/halt logic.

Test Plan:
- Reset with ROM bytes 0x10,0x11,0x12,...; instr_ready=1 held → instr_data 0x10,0x11,0x12,... one per cycle with instr_addr 0,1,2,...; first valid is 1 cycle after reset release.
- instr_ready=0 for 10 cycles → FIFO fills to 4 entries (0x10..0x13), state S_HOLD, fpc=4, irom_addr0/1 = 4/5; then ready=1 → 0x14 follows 0x13 with no gap.
- redirect_valid with redirect_addr=0x3FFE while FIFO is full → next cycle instr_valid=0; then bytes from 0x3FFE, 0x3FFF, 0x0000 in order (wrap).
- Redirect asserted in the same cycle as a pop of 0x12 → 0x12 is consumed exactly once, no stale entry follows, next valid instr_addr = redirect_addr.
- halt_req=1 with 3 entries queued, ready=1 → 3 bytes drain, halted=1, irom addresses frozen; halt_req=0 alone → still halted; redirect to 0x0100 → fetch resumes at 0x0100.
- Reset asserted mid-stream with FIFO half full → next cycle instr_valid=0, fpc=RESET_ADDR; with MCPU_IFETCH_STATS_EN defined, fetch_count=0 and flush_count=0.
